// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit lab ISA. The instruction loader and the
// datapath decoder both use this package, so the packer and the unpacker
// always agree on the bit layout.
//
// Contents: opcode constants, instruction field bit positions, the loader
// FSM state type, and the is_rtype()/is_legal() opcode classifiers.
package isa_pkg;

    localparam int INSTR_W = 16;

    // Opcodes
    localparam logic [3:0] OP_LW   = 4'b0000;
    localparam logic [3:0] OP_SW   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_INV  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_ANDI = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_ORI  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;
    localparam logic [3:0] OP_CLR  = 4'b1101;

    // Field bit positions inside the 16-bit word
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RS_MSB     = 11;
    localparam int RS_LSB     = 10;
    localparam int RT_MSB     = 9;
    localparam int RT_LSB     = 8;
    localparam int RD_MSB     = 7;
    localparam int RD_LSB     = 6;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } loader_state_e;

    // R-format words carry rd in [7:6]; everything else carries imm in [7:0].
    function automatic logic is_rtype(input logic [3:0] opcode);
        case (opcode)
            OP_ADD, OP_INV, OP_AND, OP_OR, OP_CLR: is_rtype = 1'b1;
            default:                               is_rtype = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] opcode);
        case (opcode)
            OP_LW, OP_SW, OP_ADD, OP_ADDI, OP_INV, OP_AND, OP_ANDI,
            OP_OR, OP_ORI, OP_SRA, OP_SLL, OP_BEQ, OP_BNE, OP_CLR:
                is_legal = 1'b1;
            default:
                is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational field-to-word encoder for the 16-bit lab ISA.
//
// Ports:
//   opcode_i, rs_i, rt_i, rd_i, imm_i : decoded instruction fields
//   word_o                            : packed 16-bit instruction word
//   legal_o                           : opcode is a defined instruction
module instr_packer
    import isa_pkg::*;
(
    input  logic [3:0]         opcode_i,
    input  logic [1:0]         rs_i,
    input  logic [1:0]         rt_i,
    input  logic [1:0]         rd_i,
    input  logic [7:0]         imm_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               legal_o
);

    always_comb begin
        word_o                        = '0;
        word_o[OPCODE_MSB:OPCODE_LSB] = opcode_i;
        word_o[RS_MSB:RS_LSB]         = rs_i;
        word_o[RT_MSB:RT_LSB]         = rt_i;
        // R-format leaves [5:0] zero; I-format ignores rd entirely.
        if (is_rtype(opcode_i)) begin
            word_o[RD_MSB:RD_LSB] = rd_i;
        end else begin
            word_o[IMM_MSB:IMM_LSB] = imm_i;
        end
    end

    assign legal_o = is_legal(opcode_i);

endmodule

// File: rtl/instr_loader.sv
// Sequential instruction loader: accepts decoded field bundles over a
// valid/ready handshake, packs them, and writes each legal word to the
// instruction memory at an auto-incrementing address. Illegal opcodes are
// counted and dropped.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start_i / finish_i       : begin (or restart) / end a load session
//   in_valid_i / in_ready_o  : field bundle handshake
//   opcode_i .. imm_i        : decoded instruction fields
//   imem_we_o/addr_o/wdata_o : instruction memory write port
//   word_cnt_o / err_cnt_o   : words written / illegal bundles this session
//   busy_o / done_o          : session in progress / session finished
module instr_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                finish_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [3:0]          opcode_i,
    input  logic [1:0]          rs_i,
    input  logic [1:0]          rt_i,
    input  logic [1:0]          rd_i,
    input  logic [7:0]          imm_i,
    output logic                imem_we_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    output logic [INSTR_W-1:0]  imem_wdata_o,
    output logic [ADDR_W:0]     word_cnt_o,
    output logic [7:0]          err_cnt_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    loader_state_e        state_q;
    logic                 imem_we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [INSTR_W-1:0]   wdata_q;
    logic [ADDR_W:0]      word_cnt_q;
    logic [7:0]           err_cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic [ADDR_W-1:0]    addr_d;
    logic [ADDR_W:0]      word_cnt_d;
    logic [7:0]           err_cnt_d;
    logic [INSTR_W-1:0]   packed_word;
    logic                 packed_legal;

    instr_packer u_packer (
        .opcode_i (opcode_i),
        .rs_i     (rs_i),
        .rt_i     (rt_i),
        .rd_i     (rd_i),
        .imm_i    (imm_i),
        .word_o   (packed_word),
        .legal_o  (packed_legal)
    );

    assign addr_d     = addr_q + ADDR_ONE;
    assign word_cnt_d = word_cnt_q + CNT_ONE;
    // Saturate so 256+ illegal bundles do not wrap back to a small count.
    assign err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // finish wins over in_valid, so ready is withheld in a finishing cycle.
    assign in_ready_o = (state_q == ST_LOAD) && !finish_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            imem_we_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q    <= ST_LOAD;
                        addr_q     <= '0;
                        word_cnt_q <= '0;
                        err_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (finish_i) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (in_valid_i) begin
                        if (packed_legal) begin
                            wdata_q   <= packed_word;
                            imem_we_q <= 1'b1;
                            state_q   <= ST_WRITE;
                        end else begin
                            err_cnt_q <= err_cnt_d;
                        end
                    end
                end
                ST_WRITE: begin
                    imem_we_q  <= 1'b0;
                    word_cnt_q <= word_cnt_d;
                    // The last location ends the session; the address is
                    // held there rather than wrapping to 0.
                    if (addr_q == ADDR_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q  <= addr_d;
                        state_q <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_cnt_o   = word_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
